// File: rtl/npu_stream_pkg.sv
// Shared encodings for the NPU stream controller.
// FSM states, core op codes and the per-job config bundle.
package npu_stream_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CLR   = 2'd1;
    localparam logic [1:0] ST_ISSUE = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_MUL = 2'b01;
    localparam logic [1:0] OP_RQT = 2'b10;

    typedef struct packed {
        logic [1:0] op;
        logic       inv_a;
        logic       inv_b;
    } job_cfg_t;

endpackage

// File: rtl/npu_stream_wr.sv
// Result capture: writes core results to consecutive addresses,
// drops excess results and tracks idle cycles while draining.
module npu_stream_wr #(
    parameter int AW      = 16,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear_i,
    input  logic          active_i,
    input  logic          drain_i,
    input  logic [AW-1:0] len_i,
    input  logic          output_en_i,
    input  logic [7:0]    c_out_i,
    output logic          wr_en_o,
    output logic [AW-1:0] wr_addr_o,
    output logic [7:0]    wr_data_o,
    output logic          complete_o,
    output logic          timeout_o
);

    localparam int IW = $clog2(TIMEOUT + 1);

    logic          wr_en_q,   wr_en_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]    wr_data_q, wr_data_d;
    logic [AW-1:0] wr_cnt_q,  wr_cnt_d;
    logic [IW-1:0] idle_q,    idle_d;

    assign complete_o = drain_i && (wr_cnt_q == len_i);
    assign timeout_o  = drain_i && (idle_q == IW'(TIMEOUT));

    // Next-state: accept results until LENGTH written, count idle drain cycles
    always_comb begin
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        wr_cnt_d  = wr_cnt_q;
        idle_d    = idle_q;
        if (clear_i) begin
            wr_cnt_d = '0;
        end else if (active_i && output_en_i && (wr_cnt_q < len_i)) begin
            wr_en_d   = 1'b1;
            wr_addr_d = wr_cnt_q;
            wr_data_d = c_out_i;
            wr_cnt_d  = wr_cnt_q + AW'(1);
        end
        if (!drain_i || output_en_i) begin
            idle_d = '0;
        end else if (!timeout_o) begin
            idle_d = idle_q + IW'(1);
        end
    end

    // Result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_cnt_q  <= '0;
            idle_q    <= '0;
        end else begin
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            wr_cnt_q  <= wr_cnt_d;
            idle_q    <= idle_d;
        end
    end

    assign wr_en_o   = wr_en_q;
    assign wr_addr_o = wr_addr_q;
    assign wr_data_o = wr_data_q;

endmodule

// File: rtl/npu_stream_ctrl.sv
// Job sequencer for the NPU elementwise core: clears the core,
// streams operand pairs from RAM and hands results to the writer.
module npu_stream_ctrl
    import npu_stream_pkg::*;
#(
    parameter int AW         = 16,
    parameter int CLR_CYCLES = 2,
    parameter int TIMEOUT    = 255
) (
    input  logic          CLK,
    input  logic          RESET_X,
    input  logic          START,
    input  logic [AW-1:0] LENGTH,
    input  logic [1:0]    OP_CFG,
    input  logic          INV_A_CFG,
    input  logic          INV_B_CFG,
    output logic          RD_EN,
    output logic [AW-1:0] RD_ADDR,
    input  logic [7:0]    RD_A_DATA,
    input  logic [7:0]    RD_B_DATA,
    output logic          SOFT_RESET,
    output logic [1:0]    OP,
    output logic          INV_ASEL,
    output logic          INV_BSEL,
    output logic          INPUT_EN,
    output logic [7:0]    A_IN,
    output logic [7:0]    B_IN,
    input  logic          OUTPUT_EN,
    input  logic [7:0]    C_OUT,
    output logic          WR_EN,
    output logic [AW-1:0] WR_ADDR,
    output logic [7:0]    WR_DATA,
    output logic          BUSY,
    output logic          DONE,
    output logic          ERR
);

    logic [1:0]    state_q,   state_d;
    logic [AW-1:0] len_q,     len_d;
    job_cfg_t      cfg_q,     cfg_d;
    logic [AW-1:0] rd_cnt_q,  rd_cnt_d;
    logic [3:0]    clr_cnt_q, clr_cnt_d;
    logic          busy_q,    busy_d;
    logic          done_q,    done_d;
    logic          err_q,     err_d;
    logic          soft_q,    soft_d;
    logic          rd_en_q,   rd_en_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    logic          v1_q;
    logic          in_en_q;
    logic [7:0]    a_q,       b_q;
    logic          job_start;
    logic          wr_complete;
    logic          wr_timeout;

    // Job FSM next-state and registered control outputs
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        cfg_d     = cfg_q;
        rd_cnt_d  = rd_cnt_q;
        clr_cnt_d = clr_cnt_q;
        busy_d    = busy_q;
        err_d     = err_q;
        rd_addr_d = rd_addr_q;
        done_d    = 1'b0;
        soft_d    = 1'b0;
        rd_en_d   = 1'b0;
        job_start = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (START) begin
                    err_d = 1'b0;
                    if (LENGTH != '0) begin
                        job_start = 1'b1;
                        len_d     = LENGTH;
                        cfg_d     = '{OP_CFG, INV_A_CFG, INV_B_CFG};
                        rd_cnt_d  = '0;
                        clr_cnt_d = '0;
                        busy_d    = 1'b1;
                        soft_d    = 1'b1;
                        state_d   = ST_CLR;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_CLR: begin
                if (clr_cnt_q == 4'(CLR_CYCLES - 1)) begin
                    state_d   = ST_ISSUE;
                    rd_en_d   = 1'b1;
                    rd_addr_d = rd_cnt_q;
                    rd_cnt_d  = rd_cnt_q + AW'(1);
                end else begin
                    clr_cnt_d = clr_cnt_q + 4'd1;
                    soft_d    = 1'b1;
                end
            end
            ST_ISSUE: begin
                if (rd_cnt_q == len_q) begin
                    state_d = ST_DRAIN;
                end else begin
                    rd_en_d   = 1'b1;
                    rd_addr_d = rd_cnt_q;
                    rd_cnt_d  = rd_cnt_q + AW'(1);
                end
            end
            ST_DRAIN: begin
                if (wr_complete || wr_timeout) begin
                    done_d  = 1'b1;
                    err_d   = !wr_complete;
                    busy_d  = 1'b0;
                    cfg_d   = '{OP_ADD, 1'b0, 1'b0};
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM and control registers
    always_ff @(posedge CLK or negedge RESET_X) begin
        if (!RESET_X) begin
            state_q   <= ST_IDLE;
            len_q     <= '0;
            cfg_q     <= '{OP_ADD, 1'b0, 1'b0};
            rd_cnt_q  <= '0;
            clr_cnt_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            soft_q    <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            cfg_q     <= cfg_d;
            rd_cnt_q  <= rd_cnt_d;
            clr_cnt_q <= clr_cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            soft_q    <= soft_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
        end
    end

    // Operand pipeline: RAM data sampled one cycle after the read strobe
    always_ff @(posedge CLK or negedge RESET_X) begin
        if (!RESET_X) begin
            v1_q    <= 1'b0;
            in_en_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            v1_q    <= rd_en_q;
            in_en_q <= v1_q;
            if (v1_q) begin
                a_q <= RD_A_DATA;
                b_q <= RD_B_DATA;
            end
        end
    end

    npu_stream_wr #(
        .AW      (AW),
        .TIMEOUT (TIMEOUT)
    ) u_wr (
        .clk         (CLK),
        .rst_n       (RESET_X),
        .clear_i     (job_start),
        .active_i    (state_q != ST_IDLE),
        .drain_i     (state_q == ST_DRAIN),
        .len_i       (len_q),
        .output_en_i (OUTPUT_EN),
        .c_out_i     (C_OUT),
        .wr_en_o     (WR_EN),
        .wr_addr_o   (WR_ADDR),
        .wr_data_o   (WR_DATA),
        .complete_o  (wr_complete),
        .timeout_o   (wr_timeout)
    );

    assign RD_EN      = rd_en_q;
    assign RD_ADDR    = rd_addr_q;
    assign SOFT_RESET = soft_q;
    assign OP         = cfg_q.op;
    assign INV_ASEL   = cfg_q.inv_a;
    assign INV_BSEL   = cfg_q.inv_b;
    assign INPUT_EN   = in_en_q;
    assign A_IN       = a_q;
    assign B_IN       = b_q;
    assign BUSY       = busy_q;
    assign DONE       = done_q;
    assign ERR        = err_q;

endmodule

// File: tb/tb_npu_stream_ctrl.sv
// Directed bench for npu_stream_ctrl with RAM and core models
// and a write scoreboard.
module tb_npu_stream_ctrl;

    localparam int AW = 16;
    localparam int TO = 255;

    logic          CLK = 1'b0;
    logic          RESET_X = 1'b0;
    logic          START = 1'b0;
    logic [AW-1:0] LENGTH = '0;
    logic [1:0]    OP_CFG = '0;
    logic          INV_A_CFG = 1'b0;
    logic          INV_B_CFG = 1'b0;
    logic          RD_EN;
    logic [AW-1:0] RD_ADDR;
    logic [7:0]    RD_A_DATA = '0;
    logic [7:0]    RD_B_DATA = '0;
    logic          SOFT_RESET;
    logic [1:0]    OP;
    logic          INV_ASEL;
    logic          INV_BSEL;
    logic          INPUT_EN;
    logic [7:0]    A_IN;
    logic [7:0]    B_IN;
    logic          OUTPUT_EN = 1'b0;
    logic [7:0]    C_OUT = '0;
    logic          WR_EN;
    logic [AW-1:0] WR_ADDR;
    logic [7:0]    WR_DATA;
    logic          BUSY;
    logic          DONE;
    logic          ERR;

    npu_stream_ctrl #(.AW(AW), .CLR_CYCLES(2), .TIMEOUT(TO)) dut (
        .CLK(CLK), .RESET_X(RESET_X), .START(START), .LENGTH(LENGTH),
        .OP_CFG(OP_CFG), .INV_A_CFG(INV_A_CFG), .INV_B_CFG(INV_B_CFG),
        .RD_EN(RD_EN), .RD_ADDR(RD_ADDR),
        .RD_A_DATA(RD_A_DATA), .RD_B_DATA(RD_B_DATA),
        .SOFT_RESET(SOFT_RESET), .OP(OP),
        .INV_ASEL(INV_ASEL), .INV_BSEL(INV_BSEL),
        .INPUT_EN(INPUT_EN), .A_IN(A_IN), .B_IN(B_IN),
        .OUTPUT_EN(OUTPUT_EN), .C_OUT(C_OUT),
        .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
        .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Operand RAM: registered read, data valid the cycle after RD_EN
    logic [7:0] mem_a [0:255];
    logic [7:0] mem_b [0:255];

    always @(posedge CLK) begin
        if (RD_EN) begin
            RD_A_DATA <= mem_a[RD_ADDR[7:0]];
            RD_B_DATA <= mem_b[RD_ADDR[7:0]];
        end
    end

    // Core model: 3-cycle latency, C = A + B, limited result count
    typedef struct {
        int         due;
        logic [7:0] d;
    } res_t;
    res_t core_q[$];
    res_t cr;
    int core_lim = 0;
    int core_sent = 0;
    int core_extra = 0;
    int last_oe = 0;

    always @(negedge CLK) begin
        OUTPUT_EN = 1'b0;
        if (!RESET_X) begin
            core_q.delete();
        end else begin
            if (INPUT_EN) core_q.push_back('{cyc + 3, 8'(A_IN + B_IN)});
            if (core_q.size() > 0 && core_q[0].due <= cyc) begin
                cr = core_q.pop_front();
                if (core_sent < core_lim) begin
                    OUTPUT_EN = 1'b1;
                    C_OUT = cr.d;
                    core_sent++;
                    last_oe = cyc;
                    if (core_q.size() == 0 && core_extra > 0) begin
                        core_q.push_back('{cyc + 1, 8'hEE});
                        core_extra--;
                    end
                end
            end
        end
    end

    // Monitors and write scoreboard
    typedef struct {
        int         a;
        logic [7:0] d;
    } wr_t;
    wr_t exp_q[$];
    wr_t we;
    int rd_cyc_q[$];
    int rd_adr_q[$];
    int n_rd = 0, n_wr = 0, n_done = 0, n_sr = 0, n_busy = 0;
    int first_rd = 0, done_cyc = 0, rd_exp = 0;
    int rc, ra;
    logic [1:0] exp_op = '0;
    logic exp_ia = 1'b0, exp_ib = 1'b0;

    always @(negedge CLK) begin
        if (RESET_X) begin
            if (RD_EN) begin
                if (n_rd == 0) first_rd = cyc;
                check("rd_addr", RD_ADDR, rd_exp);
                rd_exp++;
                n_rd++;
                rd_cyc_q.push_back(cyc);
                rd_adr_q.push_back(int'(RD_ADDR));
            end
            if (INPUT_EN) begin
                check("in_pending", rd_cyc_q.size() > 0, 1);
                if (rd_cyc_q.size() > 0) begin
                    rc = rd_cyc_q.pop_front();
                    ra = rd_adr_q.pop_front();
                    check("in_latency", cyc - rc, 2);
                    check("a_in", A_IN, mem_a[ra]);
                    check("b_in", B_IN, mem_b[ra]);
                end
            end
            if (WR_EN) begin
                n_wr++;
                check("wr_pending", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    we = exp_q.pop_front();
                    check("wr_addr", WR_ADDR, we.a);
                    check("wr_data", WR_DATA, we.d);
                end
            end
            if (DONE) begin
                n_done++;
                done_cyc = cyc;
            end
            if (SOFT_RESET) n_sr++;
            if (BUSY) begin
                n_busy++;
                check("cfg_hold", {OP, INV_ASEL, INV_BSEL},
                      {exp_op, exp_ia, exp_ib});
            end else begin
                check("cfg_idle", {OP, INV_ASEL, INV_BSEL}, 0);
            end
        end
    end

    task automatic start_job(input int len, input logic [1:0] op,
                             input logic ia, input logic ib,
                             input int nret, input int extra,
                             input bit dir, output int s, output int d0);
        for (int i = 0; i < len; i++) begin
            mem_a[i] = dir ? 8'(i + 1) : 8'($urandom_range(0, 255));
            mem_b[i] = dir ? 8'(10 * (i + 1)) : 8'($urandom_range(0, 255));
        end
        exp_q.delete();
        rd_cyc_q.delete();
        rd_adr_q.delete();
        for (int i = 0; i < imin(len, nret); i++)
            exp_q.push_back('{i, 8'(mem_a[i] + mem_b[i])});
        core_lim = nret + extra;
        core_sent = 0;
        core_extra = extra;
        exp_op = op;
        exp_ia = ia;
        exp_ib = ib;
        rd_exp = 0;
        n_rd = 0;
        n_wr = 0;
        n_sr = 0;
        n_busy = 0;
        d0 = n_done;
        @(negedge CLK);
        LENGTH = AW'(len);
        OP_CFG = op;
        INV_A_CFG = ia;
        INV_B_CFG = ib;
        START = 1'b1;
        s = cyc;
        @(negedge CLK);
        START = 1'b0;
        LENGTH = 16'hAAAA;
        OP_CFG = ~op;
        INV_A_CFG = ~ia;
        INV_B_CFG = ~ib;
        check("busy_start", BUSY, len != 0);
        if (len != 0) check("err_clear", ERR, 0);
    endtask

    task automatic finish_job(input int len, input int nret,
                              input int s, input int d0);
        int bound;
        bound = 64 + 4 * len + 2 * TO;
        for (int i = 0; i < bound && n_done == d0; i++) @(negedge CLK);
        check("done_seen", n_done > d0, 1);
        repeat (8) @(negedge CLK);
        check("done_once", n_done - d0, 1);
        check("rd_count", n_rd, len);
        check("wr_count", n_wr, imin(len, nret));
        check("sb_empty", exp_q.size(), 0);
        check("err_flag", ERR, nret < len);
        check("busy_end", BUSY, 0);
        if (len != 0) begin
            check("sr_cycles", n_sr, 2);
            check("first_rd", first_rd, s + 3);
        end else begin
            check("sr_none", n_sr, 0);
            check("busy_none", n_busy, 0);
            check("done_lat", done_cyc, s + 1);
        end
    endtask

    initial begin
        int s, d0, gap;
        repeat (2) @(negedge CLK);
        check("reset_outs", |{RD_EN, RD_ADDR, SOFT_RESET, OP, INV_ASEL,
              INV_BSEL, INPUT_EN, A_IN, B_IN, WR_EN, WR_ADDR, WR_DATA,
              BUSY, DONE, ERR}, 0);
        RESET_X = 1'b1;
        repeat (2) @(negedge CLK);

        start_job(4, 2'b00, 1'b0, 1'b0, 4, 0, 1'b1, s, d0);
        finish_job(4, 4, s, d0);

        start_job(0, 2'b00, 1'b0, 1'b0, 0, 0, 1'b0, s, d0);
        finish_job(0, 0, s, d0);

        start_job(3, 2'b01, 1'b1, 1'b1, 2, 0, 1'b0, s, d0);
        finish_job(3, 2, s, d0);
        gap = done_cyc - last_oe;
        check("timeout_gap", (gap >= TO) && (gap <= TO + 4), 1);

        start_job(2, 2'b00, 1'b0, 1'b1, 2, 1, 1'b0, s, d0);
        finish_job(2, 2, s, d0);

        start_job(8, 2'b10, 1'b1, 1'b0, 8, 0, 1'b0, s, d0);
        for (int i = 0; i < 50 && n_rd < 2; i++) @(negedge CLK);
        check("mid_wait", n_rd >= 2, 1);
        LENGTH = 16'd3;
        OP_CFG = 2'b01;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        finish_job(8, 8, s, d0);

        start_job(8, 2'b01, 1'b0, 1'b1, 8, 0, 1'b0, s, d0);
        for (int i = 0; i < 50 && n_rd < 3; i++) @(negedge CLK);
        check("rst_wait", n_rd >= 3, 1);
        d0 = n_done;
        RESET_X = 1'b0;
        #1;
        check("async_rst", |{RD_EN, RD_ADDR, SOFT_RESET, OP, INV_ASEL,
              INV_BSEL, INPUT_EN, A_IN, B_IN, WR_EN, WR_ADDR, WR_DATA,
              BUSY, DONE, ERR}, 0);
        repeat (3) @(negedge CLK);
        RESET_X = 1'b1;
        repeat (4) @(negedge CLK);
        check("rst_no_done", n_done, d0);

        start_job(1, 2'b10, 1'b0, 1'b0, 1, 0, 1'b0, s, d0);
        finish_job(1, 1, s, d0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
